// File: rtl/hub75_bcm_timer_if.sv
// Line handshake between the row/bit-plane sequencer (master) and the
// HUB75 BCM display timer (slave).
interface hub75_bcm_timer_if #(
  parameter int row_w = 5,
  parameter int bit_w = 3
);
  logic             line_valid;
  logic [bit_w-1:0] pix_bit;
  logic [row_w-1:0] row;
  logic             line_req;

  modport master (output line_valid, output pix_bit, output row, input line_req);
  modport slave  (input line_valid, input pix_bit, input row, output line_req);
endinterface

// File: rtl/hub75_bcm_timer.sv
// HUB75 binary-coded-modulation display timer.
// Takes "line loaded" events from the sequencer, latches the shift register
// into the panel and keeps OE_n low for a time weighted by the bit plane.
// Optional global dimming is compiled in with `define HUB75_BRIGHTNESS_EN.
module hub75_bcm_timer #(
  parameter int vpixel_p       = 64,
  parameter int segments_p     = 2,
  parameter int bpp_p          = 8,
  parameter int base_cycles_p  = 16,
  parameter int latch_cycles_p = 2,
  parameter int dead_cycles_p  = 4,
  localparam int row_w  = $clog2(vpixel_p / segments_p),
  localparam int bit_w  = $clog2(bpp_p),
  localparam int time_w = $clog2(base_cycles_p) + bpp_p
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_enable,
  input  logic [7:0]       i_brightness,
  hub75_bcm_timer_if.slave line_if,
  output logic             o_lat,
  output logic             o_oe_n,
  output logic [row_w-1:0] o_row_addr,
  output logic             o_blanking,
  output logic             o_busy,
  output logic             o_underflow,
  output logic             o_overflow
);

  typedef enum logic [2:0] {
    IDLE, BLANK_PRE, LATCH, BLANK_POST, DISPLAY, STARVE
  } state_t;

  state_t state_q, state_d;

  logic [time_w-1:0] cnt_q, cnt_d;
  logic [time_w-1:0] on_q, on_d;
  logic [time_w-1:0] full, on_calc;
  logic              pend_q, pend_d;
  logic [bit_w-1:0]  pend_bit_q, pend_bit_d;
  logic [row_w-1:0]  pend_row_q, pend_row_d;
  logic [bit_w-1:0]  act_bit_q, act_bit_d;
  logic [row_w-1:0]  row_q, row_d;
  logic              lat_q, lat_d, oe_n_q, oe_n_d, blank_q, blank_d;
  logic              req_q, req_d, busy_q, busy_d;
  logic              unf_q, unf_d, ovf_q, ovf_d, en_q;
  logic              done, enter, consume, en_rise;

  assign done    = (cnt_q == '0);
  assign en_rise = i_enable & ~en_q;
  assign full    = time_w'(base_cycles_p) << act_bit_q;

`ifdef HUB75_BRIGHTNESS_EN
  localparam int prod_w = time_w + 9;
  logic [prod_w-1:0] bright_prod;
  assign bright_prod = prod_w'(full) * prod_w'({1'b0, i_brightness} + 9'd1);
  assign on_calc     = time_w'(bright_prod >> 8);
`else
  logic unused_brightness;
  assign unused_brightness = ^i_brightness;
  assign on_calc           = full;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, counter reload, pending slot and next registered outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_bit_d = pend_bit_q;
    pend_row_d = pend_row_q;
    act_bit_d  = act_bit_q;
    row_d      = row_q;
    on_d       = on_q;

    case (state_q)
      IDLE:       if (pend_q) state_d = BLANK_PRE;
      BLANK_PRE:  if (done)   state_d = LATCH;
      LATCH:      if (done)   state_d = BLANK_POST;
      BLANK_POST: if (done)   state_d = DISPLAY;
      DISPLAY:    if (done)   state_d = pend_q ? BLANK_PRE : STARVE;
      STARVE:     if (pend_q) state_d = BLANK_PRE;
      default:                state_d = IDLE;
    endcase
    if (!i_enable) state_d = IDLE;

    enter   = (state_d != state_q);
    consume = enter && (state_d == LATCH);

    if (enter) begin
      case (state_d)
        BLANK_PRE, BLANK_POST: cnt_d = time_w'(dead_cycles_p - 1);
        LATCH:                 cnt_d = time_w'(latch_cycles_p - 1);
        DISPLAY:               cnt_d = full - time_w'(1);
        default:               cnt_d = '0;
      endcase
    end else if (!done) begin
      cnt_d = cnt_q - time_w'(1);
    end

    if (!i_enable) begin
      pend_d = 1'b0;
    end else if (consume || !pend_q) begin
      pend_d = line_if.line_valid;
      if (line_if.line_valid) begin
        pend_bit_d = line_if.pix_bit;
        pend_row_d = line_if.row;
      end
    end

    if (consume) begin
      act_bit_d = pend_bit_q;
      row_d     = pend_row_q;
    end
    if (enter && state_d == DISPLAY) on_d = on_calc;

    lat_d   = (state_d == LATCH);
    oe_n_d  = !((state_d == DISPLAY) && (cnt_d >= full - on_d));
    blank_d = (state_d != DISPLAY);
    busy_d  = (state_d != IDLE);
    req_d   = (state_q == LATCH) && (state_d == BLANK_POST);
    unf_d   = (en_rise ? 1'b0 : unf_q)
            | (i_enable && state_q == DISPLAY && done && !pend_q);
    ovf_d   = (en_rise ? 1'b0 : ovf_q)
            | (i_enable && line_if.line_valid && pend_q && !consume);
  end

  // Datapath, pending slot and registered panel outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      on_q       <= '0;
      pend_q     <= 1'b0;
      pend_bit_q <= '0;
      pend_row_q <= '0;
      act_bit_q  <= '0;
      row_q      <= '0;
      lat_q      <= 1'b0;
      oe_n_q     <= 1'b1;
      blank_q    <= 1'b1;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      unf_q      <= 1'b0;
      ovf_q      <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      on_q       <= on_d;
      pend_q     <= pend_d;
      pend_bit_q <= pend_bit_d;
      pend_row_q <= pend_row_d;
      act_bit_q  <= act_bit_d;
      row_q      <= row_d;
      lat_q      <= lat_d;
      oe_n_q     <= oe_n_d;
      blank_q    <= blank_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
      unf_q      <= unf_d;
      ovf_q      <= ovf_d;
      en_q       <= i_enable;
    end
  end

  assign o_lat            = lat_q;
  assign o_oe_n           = oe_n_q;
  assign o_row_addr       = row_q;
  assign o_blanking       = blank_q;
  assign o_busy           = busy_q;
  assign o_underflow      = unf_q;
  assign o_overflow       = ovf_q;
  assign line_if.line_req = req_q;

endmodule

// File: tb/tb_hub75_bcm_timer.sv
// Self-checking bench for hub75_bcm_timer (default parameters).
// Builds with or without HUB75_BRIGHTNESS_EN.
module tb_hub75_bcm_timer;
  localparam int row_w = 5;
  localparam int bit_w = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_enable = 1'b0;
  logic [7:0]       i_brightness = 8'd255;
  logic             o_lat, o_oe_n, o_blanking, o_busy, o_underflow, o_overflow;
  logic [row_w-1:0] o_row_addr;

  int checks = 0;
  int failures = 0;

  hub75_bcm_timer_if #(.row_w(row_w), .bit_w(bit_w)) lif();

  hub75_bcm_timer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_enable     (i_enable),
    .i_brightness (i_brightness),
    .line_if      (lif),
    .o_lat        (o_lat),
    .o_oe_n       (o_oe_n),
    .o_row_addr   (o_row_addr),
    .o_blanking   (o_blanking),
    .o_busy       (o_busy),
    .o_underflow  (o_underflow),
    .o_overflow   (o_overflow)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  typedef struct {
    logic             valid;
    logic [bit_w-1:0] pbit;
    logic [row_w-1:0] row;
    int               n;
    logic             lat;
    logic             oe_n;
    logic [row_w-1:0] raddr;
    logic             blank;
    logic             req;
    logic             busy;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [bit_w-1:0] pbit,
                               input logic [row_w-1:0] row);
    lif.line_valid = valid;
    lif.pix_bit    = pbit;
    lif.row        = row;
  endtask

  task automatic pulseLine(input logic [bit_w-1:0] pbit, input logic [row_w-1:0] row);
    applyStimulus(1'b1, pbit, row);
    tick();
    applyStimulus(1'b0, '0, '0);
  endtask

  task automatic waitOeLow(input string name);
    int n;
    n = 0;
    while (o_oe_n === 1'b1 && n < 300) begin
      tick();
      n++;
    end
    checkOutput({name, ".oe_low_reached"}, o_oe_n, 0);
  endtask

  task automatic countLow(output int n);
    n = 0;
    while (o_oe_n === 1'b0 && n < 5000) begin
      n++;
      tick();
    end
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, ".lat"},       o_lat,       0);
    checkOutput({name, ".oe_n"},      o_oe_n,      1);
    checkOutput({name, ".row_addr"},  o_row_addr,  0);
    checkOutput({name, ".blanking"},  o_blanking,  1);
    checkOutput({name, ".line_req"},  lif.line_req, 0);
    checkOutput({name, ".busy"},      o_busy,      0);
    checkOutput({name, ".underflow"}, o_underflow, 0);
    checkOutput({name, ".overflow"},  o_overflow,  0);
  endtask

  initial begin
    int n;

    // bit 0 row 5 line from IDLE, cycle by cycle, ending in STARVE
    vecs[0] = '{1'b1, 3'd0, 5'd5,  1, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 3'd0, 5'd0,  1, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 3'd0, 5'd0,  4, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 3'd0, 5'd0,  2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 3'd0, 5'd0,  1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 3'd0, 5'd0,  3, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 3'd0, 5'd0, 16, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 3'd0, 5'd0,  1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1};

    applyStimulus(1'b0, '0, '0);
    tick();
    checkResetOutputs("reset");

    rst_n = 1'b1;
    i_enable = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        if (k == 0 && vecs[i].valid) applyStimulus(1'b1, vecs[i].pbit, vecs[i].row);
        else                         applyStimulus(1'b0, '0, '0);
        checkOutput($sformatf("vec%0d.%0d.lat", i, k),      o_lat,        vecs[i].lat);
        checkOutput($sformatf("vec%0d.%0d.oe_n", i, k),     o_oe_n,       vecs[i].oe_n);
        checkOutput($sformatf("vec%0d.%0d.row_addr", i, k), o_row_addr,   vecs[i].raddr);
        checkOutput($sformatf("vec%0d.%0d.blanking", i, k), o_blanking,   vecs[i].blank);
        checkOutput($sformatf("vec%0d.%0d.line_req", i, k), lif.line_req, vecs[i].req);
        checkOutput($sformatf("vec%0d.%0d.busy", i, k),     o_busy,       vecs[i].busy);
        tick();
      end
    end
    applyStimulus(1'b0, '0, '0);

    // Starved: underflow sticky, then a late line resumes via BLANK_PRE
    checkOutput("starve.underflow", o_underflow, 1);
    checkOutput("starve.overflow",  o_overflow,  0);
    checkOutput("starve.oe_n",      o_oe_n,      1);
    pulseLine(3'd1, 5'd7);
    checkOutput("resume.s1.lat", o_lat, 0);
    repeat (4) tick();
    checkOutput("resume.s5.lat", o_lat, 0);
    tick();
    checkOutput("resume.s6.lat",      o_lat,       1);
    checkOutput("resume.s6.row_addr", o_row_addr,  7);
    checkOutput("resume.s6.underflow", o_underflow, 1);
    tick();
    tick();
    checkOutput("resume.s8.line_req", lif.line_req, 1);
    waitOeLow("resume");
    countLow(n);
    checkOutput("resume.low_cycles", n, 32);
    checkOutput("resume.underflow_end", o_underflow, 1);

    // Enable 0->1 clears sticky flags
    i_enable = 1'b0;
    tick();
    checkOutput("disable.busy", o_busy, 0);
    checkOutput("disable.oe_n", o_oe_n, 1);
    i_enable = 1'b1;
    tick();
    checkOutput("reenable.underflow", o_underflow, 0);
    checkOutput("reenable.overflow",  o_overflow,  0);

    // Bit 7 with next line pending: 2048 low cycles, straight into BLANK_PRE
    pulseLine(3'd7, 5'd3);
    waitOeLow("bit7");
    n = 0;
    while (o_oe_n === 1'b0 && n < 5000) begin
      n++;
      if (n == 100) applyStimulus(1'b1, 3'd0, 5'd4);
      else          applyStimulus(1'b0, '0, '0);
      tick();
    end
    applyStimulus(1'b0, '0, '0);
    checkOutput("bit7.low_cycles", n, 2048);
    checkOutput("bit7.end.blanking", o_blanking, 1);
    checkOutput("bit7.end.busy",     o_busy,     1);
    repeat (3) tick();
    checkOutput("bit7.e3.lat", o_lat, 0);
    tick();
    checkOutput("bit7.e4.lat",       o_lat,       1);
    checkOutput("bit7.e4.row_addr",  o_row_addr,  4);
    checkOutput("bit7.e4.underflow", o_underflow, 0);
    checkOutput("bit7.e4.overflow",  o_overflow,  0);
    waitOeLow("bit0_next");
    countLow(n);
    checkOutput("bit0_next.low_cycles", n, 16);

    // Overflow: two lines before LATCH, first one wins
    i_enable = 1'b0;
    tick();
    i_enable = 1'b1;
    tick();
    applyStimulus(1'b1, 3'd2, 5'd1);
    tick();
    applyStimulus(1'b1, 3'd0, 5'd2);
    tick();
    applyStimulus(1'b0, '0, '0);
    checkOutput("ovf.flag", o_overflow, 1);
    repeat (4) tick();
    checkOutput("ovf.lat",      o_lat,      1);
    checkOutput("ovf.row_addr", o_row_addr, 1);
    waitOeLow("ovf");
    pulseLine(3'd0, 5'd8);
    repeat (4) tick();
    checkOutput("ovf.mid_display.oe_n", o_oe_n, 0);
    i_enable = 1'b0;
    tick();
    checkOutput("drop.oe_n",     o_oe_n,     1);
    checkOutput("drop.lat",      o_lat,      0);
    checkOutput("drop.busy",     o_busy,     0);
    checkOutput("drop.blanking", o_blanking, 1);
    checkOutput("drop.row_addr", o_row_addr, 1);
    checkOutput("drop.overflow", o_overflow, 1);
    i_enable = 1'b1;
    repeat (10) tick();
    checkOutput("drop.pending_cleared.busy", o_busy,     0);
    checkOutput("drop.reenable.overflow",    o_overflow, 0);

`ifdef HUB75_BRIGHTNESS_EN
    // Global dimming: 127 gives half of a bit-3 period, 255 gives all of it
    i_brightness = 8'd127;
    pulseLine(3'd3, 5'd6);
    waitOeLow("br127");
    countLow(n);
    checkOutput("br127.low_cycles", n, 64);
    n = 0;
    while (o_oe_n === 1'b1 && o_blanking === 1'b0 && n < 5000) begin
      n++;
      tick();
    end
    checkOutput("br127.high_cycles", n, 64);
    i_brightness = 8'd255;
    pulseLine(3'd3, 5'd6);
    waitOeLow("br255");
    i_brightness = 8'd0;
    countLow(n);
    checkOutput("br255.low_cycles", n, 128);
    i_brightness = 8'd255;
`else
    // Without dimming the brightness input has no effect
    i_brightness = 8'd0;
    pulseLine(3'd3, 5'd6);
    waitOeLow("nobr");
    countLow(n);
    checkOutput("nobr.low_cycles", n, 128);
    i_brightness = 8'd255;
`endif

    // Asynchronous reset in the middle of DISPLAY
    applyStimulus(1'b1, 3'd4, 5'd9);
    tick();
    applyStimulus(1'b1, 3'd0, 5'd10);
    tick();
    applyStimulus(1'b0, '0, '0);
    waitOeLow("rst_mid");
    repeat (3) tick();
    checkOutput("rst_mid.pre_overflow", o_overflow, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("rst_mid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
